// File: rtl/hamming_serial_encoder.sv
// Serial Hamming/SECDED encoder: K data bits in, N-bit codeword out.
// Parity is accumulated on the fly; position 0 carries overall parity.
module hamming_serial_encoder #(
  parameter int M          = 4,
  parameter bit EXT_PARITY = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  output logic busy
);

  localparam int N = 1 << M;
  localparam int K = N - M - 1;
  localparam logic [M-1:0] LAST_D = M'(K - 1);
  localparam logic [M-1:0] LAST_O = M'(N - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_FINAL,
    S_SEND
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_cw;
  logic [M-1:0]   r_par;
  logic           r_ovl;
  logic [M-1:0]   r_didx;
  logic [M-1:0]   r_idx;
  logic [M-1:0]   w_pos;
  logic           w_load;
  logic           w_send;

  // Maps a data index to its codeword position, skipping 0 and powers of two.
  function automatic logic [M-1:0] f_pos(input logic [M-1:0] idx);
    logic [M-1:0] r;
    int           c;
    r = '0;
    c = 0;
    for (int q = 3; q < N; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (c == int'(idx)) r = M'(q);
        c++;
      end
    end
    return r;
  endfunction

  assign w_pos  = f_pos(r_didx);
  assign w_load = (r_state == S_LOAD);
  assign w_send = (r_state == S_SEND);

  assign in_ready  = w_load;
  assign out_valid = w_send;
  assign out_data  = w_send & r_cw[r_idx];
  assign out_last  = w_send & (r_idx == LAST_O);
  assign busy      = ~w_load;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_next;
  end

  // Next-state decode: load K bits, one finalise cycle, then stream N bits.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD:  if (in_valid && r_didx == LAST_D) w_next = S_FINAL;
      S_FINAL: w_next = S_SEND;
      S_SEND:  if (out_ready && r_idx == LAST_O) w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  // Codeword assembly, parity accumulation and output indexing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cw   <= '0;
      r_par  <= '0;
      r_ovl  <= 1'b0;
      r_didx <= '0;
      r_idx  <= '0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            r_cw[w_pos] <= in_data;
            for (int i = 0; i < M; i++)
              r_par[i] <= r_par[i] ^ (in_data & w_pos[i]);
            r_ovl  <= r_ovl ^ in_data;
            r_didx <= (r_didx == LAST_D) ? '0 : r_didx + 1'b1;
          end
        end
        S_FINAL: begin
          for (int i = 0; i < M; i++)
            r_cw[1 << i] <= r_par[i];
          r_cw[0] <= EXT_PARITY ? (^r_par ^ r_ovl) : 1'b0;
          r_idx   <= '0;
        end
        S_SEND: begin
          if (out_ready) begin
            if (r_idx == LAST_O) begin
              r_cw   <= '0;
              r_par  <= '0;
              r_ovl  <= 1'b0;
              r_didx <= '0;
              r_idx  <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_serial_encoder.sv
// Directed bench for hamming_serial_encoder.
// Three instances: M=4 SECDED, M=4 plain, M=3 SECDED.
module tb_hamming_serial_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] id, iv, ir, od, ov, ordy, ol, bz;
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  hamming_serial_encoder #(.M(4), .EXT_PARITY(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(id[0]), .in_valid(iv[0]),
    .in_ready(ir[0]), .out_data(od[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_last(ol[0]), .busy(bz[0]));

  hamming_serial_encoder #(.M(4), .EXT_PARITY(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(id[1]), .in_valid(iv[1]),
    .in_ready(ir[1]), .out_data(od[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_last(ol[1]), .busy(bz[1]));

  hamming_serial_encoder #(.M(3), .EXT_PARITY(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(id[2]), .in_valid(iv[2]),
    .in_ready(ir[2]), .out_data(od[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_last(ol[2]), .busy(bz[2]));

  task automatic chk(input string tag, input logic o, input logic e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: got %b expected %b", tag, o, e);
    end
  endtask

  task automatic load(input int k, input logic [63:0] d,
                      input int n, input bit hold);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      iv[k] = 1'b1;
      id[k] = d[i];
      while (!ir[k] && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!ir[k]) chk("load_timeout", 1'b1, 1'b0);
      @(negedge clk);
    end
    if (!hold) iv[k] = 1'b0;
  endtask

  task automatic recv(input int k, input logic [63:0] e, input int n,
                      input int stop, input bit rnd);
    int idx;
    int t;
    idx = 0;
    t = 0;
    while (idx < stop && t < 400) begin
      @(negedge clk);
      t++;
      ordy[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ov[k]) begin
        chk("out_data", od[k], e[idx]);
        chk("out_last", ol[k], idx == n - 1);
        chk("ir_send", ir[k], 1'b0);
        chk("busy_send", bz[k], 1'b1);
        if (ordy[k]) idx++;
      end
    end
    if (idx < stop) chk("recv_timeout", 1'b1, 1'b0);
  endtask

  task automatic final_chk(input int k);
    chk("fin_ov", ov[k], 1'b0);
    chk("fin_ir", ir[k], 1'b0);
    chk("fin_busy", bz[k], 1'b1);
  endtask

  task automatic idle_chk(input int k);
    @(negedge clk);
    chk("idle_ir", ir[k], 1'b1);
    chk("idle_ov", ov[k], 1'b0);
    chk("idle_last", ol[k], 1'b0);
    chk("idle_busy", bz[k], 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    iv = '0;
    id = '0;
    ordy = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ir", ir[k], 1'b1);
      chk("rst_ov", ov[k], 1'b0);
      chk("rst_last", ol[k], 1'b0);
      chk("rst_od", od[k], 1'b0);
      chk("rst_busy", bz[k], 1'b0);
    end
    rst_n = 1'b1;

    load(0, 64'h0, 11, 1'b0);
    final_chk(0);
    recv(0, 64'h0, 16, 16, 1'b0);
    idle_chk(0);

    load(0, 64'h001, 11, 1'b0);
    final_chk(0);
    recv(0, 64'h000F, 16, 16, 1'b0);
    idle_chk(0);

    load(0, 64'h7FF, 11, 1'b0);
    final_chk(0);
    recv(0, 64'hFFFF, 16, 16, 1'b0);
    idle_chk(0);

    load(1, 64'h7FF, 11, 1'b0);
    final_chk(1);
    recv(1, 64'hFFFE, 16, 16, 1'b0);
    idle_chk(1);

    load(2, 64'hD, 4, 1'b0);
    final_chk(2);
    recv(2, 64'hCC, 8, 8, 1'b0);
    idle_chk(2);
    load(2, 64'hD, 4, 1'b0);
    recv(2, 64'hCC, 8, 8, 1'b1);
    idle_chk(2);

    load(0, 64'h1F, 5, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rl_ir", ir[0], 1'b1);
    chk("rl_ov", ov[0], 1'b0);
    chk("rl_busy", bz[0], 1'b0);
    load(0, 64'h001, 11, 1'b0);
    final_chk(0);
    recv(0, 64'h000F, 16, 7, 1'b0);
    @(negedge clk);
    chk("mid_ov", ov[0], 1'b1);
    chk("mid_od7", od[0], 1'b0);
    rst_n = 1'b0;
    ordy[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rs_ov", ov[0], 1'b0);
    chk("rs_ir", ir[0], 1'b1);
    chk("rs_last", ol[0], 1'b0);
    chk("rs_busy", bz[0], 1'b0);
    load(0, 64'h7FF, 11, 1'b0);
    final_chk(0);
    recv(0, 64'hFFFF, 16, 16, 1'b0);
    idle_chk(0);

    fork
      begin
        load(0, 64'h001, 11, 1'b1);
        load(0, 64'h7FF, 11, 1'b0);
      end
      begin
        recv(0, 64'h000F, 16, 16, 1'b0);
        recv(0, 64'hFFFF, 16, 16, 1'b0);
      end
    join
    idle_chk(0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
